// File: rtl/conv1x1_out_collector_pkg.sv
// conv1x1_out_collector_pkg: shared widths, derived sizes and FIFO entry type for the 1x1 conv output collector
package conv1x1_out_collector_pkg;
    localparam int DATW = 16;
    localparam int PAR  = 16;
    function automatic int slices_f(input int in_ch);
        return in_ch / PAR;
    endfunction
    function automatic int pix_total_f(input int out_size);
        return out_size * out_size;
    endfunction
    // A counter over n states needs at least one bit even when n is 1
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    typedef struct packed {
        logic            last;
        logic [DATW-1:0] data;
    } entry_t;
endpackage

// File: rtl/conv_out_fifo.sv
// conv_out_fifo: count-based synchronous FIFO
// Ports: clk, rst (sync, active-high); wr_en/wr_data push; rd_en pops the head;
//        rd_data is the head entry; count/full/empty report occupancy.
module conv_out_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_rd, do_wr;
    // A write into a full FIFO is accepted only when the head leaves in the same cycle
    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
endmodule

// File: rtl/conv1x1_out_collector.sv
// conv1x1_out_collector: counts slice beats per pixel, captures the core result, buffers it for the writer
// Ports: clk, rst (sync, active-high); conv_valid/conv_data from the core; first_slice to the core;
//        stall backpressure to upstream; out_data/out_last/out_valid/out_ready to the writer;
//        frame_done one-cycle pulse after the last pixel capture; overflow sticky drop flag.
// Build option: define CONV1X1_RELU_EN to clamp negative results to zero.
module conv1x1_out_collector #(
    parameter int DATW       = 16,
    parameter int IN_CH      = 64,
    parameter int OUT_SIZE   = 55,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            conv_valid,
    input  logic [DATW-1:0] conv_data,
    output logic            first_slice,
    output logic            stall,
    output logic [DATW-1:0] out_data,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            frame_done,
    output logic            overflow
);
    import conv1x1_out_collector_pkg::*;
    localparam int SLICES    = slices_f(IN_CH);
    localparam int PIX_TOTAL = pix_total_f(OUT_SIZE);
    localparam int SW        = cnt_w(SLICES);
    localparam int PW        = cnt_w(PIX_TOTAL);
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    logic [SW-1:0]   slice_cnt_q, slice_cnt_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic            cap_pend_q, cap_pend_d;
    logic            frame_done_q, frame_done_d;
    logic            overflow_q, overflow_d;
    logic            slice_last, pix_last, rd_en;
    logic [DATW-1:0] cap_data;
    logic [DATW:0]   wr_entry, rd_entry;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    always_comb begin
        slice_last   = slice_cnt_q == SW'(SLICES - 1);
        pix_last     = pix_cnt_q == PW'(PIX_TOTAL - 1);
        rd_en        = !fifo_empty && out_ready;
`ifdef CONV1X1_RELU_EN
        cap_data     = conv_data[DATW-1] ? '0 : conv_data;
`else
        cap_data     = conv_data;
`endif
        wr_entry     = {pix_last, cap_data};
        slice_cnt_d  = conv_valid ? (slice_last ? '0 : slice_cnt_q + 1'b1) : slice_cnt_q;
        // The core's accumulator settles on the last beat's edge, so sample one cycle later
        cap_pend_d   = conv_valid && slice_last;
        pix_cnt_d    = cap_pend_q ? (pix_last ? '0 : pix_cnt_q + 1'b1) : pix_cnt_q;
        frame_done_d = cap_pend_q && pix_last;
        overflow_d   = overflow_q || (cap_pend_q && fifo_full && !rd_en);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            slice_cnt_q  <= '0;
            pix_cnt_q    <= '0;
            cap_pend_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            slice_cnt_q  <= slice_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            cap_pend_q   <= cap_pend_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end
    conv_out_fifo #(.W(DATW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap_pend_q),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
    assign first_slice = slice_cnt_q == '0;
    // Two slots of headroom plus the pending capture keep one in-flight result from being dropped
    assign stall       = (fifo_count >= CW'(FIFO_DEPTH - 2)) || cap_pend_q;
    assign out_data    = rd_entry[DATW-1:0];
    assign out_last    = rd_entry[DATW];
    assign out_valid   = !fifo_empty;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_conv1x1_out_collector.sv
// tb_conv1x1_out_collector: randomized and directed checks against a queue-based reference model
module tb_conv1x1_out_collector;
    localparam int SLICES = 4;
    localparam int PIX    = 9;
    localparam int DEPTH  = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conv_valid = 1'b0;
    logic [15:0] conv_data = '0;
    logic        out_ready = 1'b0;
    logic        first_slice, stall, out_last, out_valid, frame_done, overflow;
    logic [15:0] out_data;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] mq[$];
    logic [16:0] got[$];
    logic [15:0] vals[$];
    int          beats = 0;
    int          pix = 0;
    bit          cap_m = 0;
    bit          ovf_m = 0;
    bit          fd_m = 0;
    bit          started = 0;
    int          fd_cnt = 0;
    conv1x1_out_collector #(.DATW(16), .IN_CH(64), .OUT_SIZE(3), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .conv_valid  (conv_valid),
        .conv_data   (conv_data),
        .first_slice (first_slice),
        .stall       (stall),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [15:0] relu_m(input logic [15:0] v);
`ifdef CONV1X1_RELU_EN
        return ($signed(v) < 0) ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction
    // Reference model: a pixel completes on every SLICES-th beat; its result is the data one cycle later
    always @(posedge clk) begin
        logic lst;
        if (rst) begin
            mq.delete();
            beats = 0;
            pix = 0;
            cap_m = 0;
            ovf_m = 0;
            fd_m = 0;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            fd_m = 0;
            if (cap_m) begin
                lst = (pix == PIX - 1);
                if (mq.size() < DEPTH) mq.push_back({lst, relu_m(conv_data)});
                else ovf_m = 1;
                fd_m = lst;
                pix = (pix + 1) % PIX;
            end
            cap_m = conv_valid && (beats % SLICES == SLICES - 1);
            if (conv_valid) beats++;
        end
        started = 1;
    end
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("out_data", out_data, mq[0][15:0]);
                chk("out_last", out_last, mq[0][16]);
            end
            chk("first_slice", first_slice, beats % SLICES == 0);
            chk("stall", stall, (mq.size() >= DEPTH - 2) || cap_m);
            chk("overflow", overflow, ovf_m);
            chk("frame_done", frame_done, fd_m);
            if (out_valid && out_ready) got.push_back({out_last, out_data});
            if (frame_done) fd_cnt++;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        conv_valid = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask
    task automatic send_pixel(input logic [15:0] v, input bit honor);
        for (int s = 0; s < SLICES; s++) begin
            int n = 0;
            if (honor) begin
                while (stall && n < 200) begin
                    conv_data = 16'($urandom);
                    tick();
                    n++;
                end
                chk("stall_wait_bound", n >= 200, 0);
            end
            conv_valid = 1;
            conv_data = 16'($urandom);
            tick();
            conv_valid = 0;
        end
        conv_data = v;
        tick();
        conv_data = 16'($urandom);
    endtask
    initial begin
        logic [4:0]  pat;
        logic [15:0] v;
        int          n;
        do_reset();
        @(negedge clk);
        chk("rst_first_slice", first_slice, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall, 0);
        tick();
        // Single pixel, directed timing
        out_ready = 1;
        for (int i = 0; i < SLICES; i++) begin
            conv_valid = 1;
            conv_data = 16'($urandom);
            @(negedge clk) pat[i] = first_slice;
            tick();
        end
        conv_valid = 0;
        conv_data = 16'h0120;
        @(negedge clk) pat[4] = first_slice;
        tick();
        conv_data = 16'($urandom);
        @(negedge clk);
        chk("first_slice_pattern", pat, 5'b10001);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_data", out_data, 16'h0120);
        chk("lat_out_last", out_last, 0);
        tick();
        // Negative result
        got.delete();
        send_pixel(16'hFF00, 1);
        repeat (4) tick();
        chk("neg_count", got.size(), 1);
`ifdef CONV1X1_RELU_EN
        chk("neg_relu", got[0][15:0], 16'h0000);
`else
        chk("neg_pass", got[0][15:0], 16'hFF00);
`endif
        // Full frame plus one
        do_reset();
        got.delete();
        vals.delete();
        fd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            v = 16'($urandom);
            vals.push_back(v);
            send_pixel(v, 1);
        end
        repeat (5) tick();
        chk("frame_count", got.size(), 10);
        chk("frame_first_last", got[0][16], 0);
        chk("frame_9th_last", got[8][16], 1);
        chk("frame_10th_last", got[9][16], 0);
        chk("frame_9th_data", got[8][15:0], relu_m(vals[8]));
        chk("frame_done_pulses", fd_cnt, 1);
        // Backpressure honoured with consumer stopped
        do_reset();
        out_ready = 0;
        got.delete();
        vals.delete();
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom);
            vals.push_back(v);
            send_pixel(v, 1);
        end
        repeat (3) tick();
        @(negedge clk);
        chk("bp_stall", stall, 1);
        chk("bp_overflow", overflow, 0);
        tick();
        out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            v = 16'($urandom);
            vals.push_back(v);
            send_pixel(v, 1);
        end
        repeat (12) tick();
        chk("bp_drain_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_drain_order", got[i][15:0], relu_m(vals[i]));
        // Protocol violation until a capture hits a full FIFO
        do_reset();
        out_ready = 0;
        conv_valid = 1;
        n = 0;
        while (!overflow && n < 300) begin
            conv_data = 16'($urandom);
            tick();
            n++;
        end
        conv_valid = 0;
        chk("ovf_reached", n < 300, 1);
        repeat (5) tick();
        @(negedge clk);
        chk("ovf_sticky", overflow, 1);
        tick();
        got.delete();
        out_ready = 1;
        repeat (12) tick();
        chk("ovf_drain_count", got.size(), 8);
        // Reset mid-pixel
        do_reset();
        got.delete();
        for (int i = 0; i < 2; i++) begin
            conv_valid = 1;
            tick();
        end
        conv_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("mid_rst_first_slice", first_slice, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        tick();
        send_pixel(16'h1234, 1);
        repeat (4) tick();
        chk("mid_rst_count", got.size(), 1);
        chk("mid_rst_data", got[0][15:0], 16'h1234);
        // Random traffic honouring stall
        do_reset();
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom % 4) != 0;
            conv_valid = !stall && (($urandom % 3) != 0);
            conv_data = 16'($urandom);
            tick();
        end
        conv_valid = 0;
        out_ready = 1;
        repeat (12) tick();
        chk("rand_no_overflow", overflow, 0);
        chk("rand_drained", out_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
